// File: rtl/mcu_local_axil_write_fsm.sv
// Local write-side FSM: drains an AXI-Stream of result words into an AXI-Lite slave,
// one outstanding write at a time, with wrapping word address and bounded pass count.
module mcu_local_axil_write_fsm #(
    parameter int                       GLO_FSM_WIDTH    = 2,
    parameter logic [GLO_FSM_WIDTH-1:0] GLO_FSM_STR      = 2'd1,
    parameter logic [GLO_FSM_WIDTH-1:0] GLO_FSM_END      = 2'd2,
    parameter logic [GLO_FSM_WIDTH-1:0] GLO_FSM_ERR      = 2'd3,
    parameter int                       DATA_WIDTH       = 16,
    parameter int                       ADDR_WIDTH       = 32,
    parameter int                       STRB_WIDTH       = DATA_WIDTH/8,
    parameter int                       INTER_ITER_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic                        s_axis_tlast,
    output logic [ADDR_WIDTH-1:0]       m_axil_awaddr,
    output logic [2:0]                  m_axil_awprot,
    output logic                        m_axil_awvalid,
    input  logic                        m_axil_awready,
    output logic [DATA_WIDTH-1:0]       m_axil_wdata,
    output logic [STRB_WIDTH-1:0]       m_axil_wstrb,
    output logic                        m_axil_wvalid,
    input  logic                        m_axil_wready,
    input  logic [1:0]                  m_axil_bresp,
    input  logic                        m_axil_bvalid,
    output logic                        m_axil_bready,
    input  logic [GLO_FSM_WIDTH-1:0]    glo_fsm_state,
    input  logic [ADDR_WIDTH:0]         addr_counter_max,
    input  logic [INTER_ITER_WIDTH-1:0] inter_counter_max,
    output logic                        write_done,
    output logic                        error
);

    // OPE is split into its ACCEPT / ISSUE / RESP sub-phases
    localparam logic [2:0] ST_STR = 3'd0;
    localparam logic [2:0] ST_ACC = 3'd1;
    localparam logic [2:0] ST_ISS = 3'd2;
    localparam logic [2:0] ST_RSP = 3'd3;
    localparam logic [2:0] ST_ERR = 3'd4;
    localparam logic [2:0] ST_END = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [INTER_ITER_WIDTH-1:0] pass_q, pass_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic                        awvalid_q, awvalid_d;
    logic                        wvalid_q, wvalid_d;
    logic                        bready_q, bready_d;
    logic                        done_q, done_d;
    logic                        error_q, error_d;
    logic                        abort_q, abort_d;

    logic                        glo_err;
    logic [ADDR_WIDTH:0]         addr_sum;
    logic [INTER_ITER_WIDTH:0]   pass_sum;
    logic                        addr_wrap;
    logic                        is_last;

    assign glo_err   = (glo_fsm_state == GLO_FSM_ERR);
    assign addr_sum  = {1'b0, addr_q} + 1'b1;
    assign pass_sum  = {1'b0, pass_q} + 1'b1;
    assign addr_wrap = (addr_sum == addr_counter_max);
    assign is_last   = addr_wrap && (pass_sum == {1'b0, inter_counter_max});

    // A global ERR must stop new words immediately, hence the direct gating
    assign s_axis_tready  = (state_q == ST_ACC) && !glo_err;
    assign m_axil_awaddr  = addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = '1;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign write_done     = done_q;
    assign error          = error_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pass_d    = pass_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        abort_d   = abort_q;
        case (state_q)
            ST_STR: begin
                if (glo_fsm_state == GLO_FSM_STR) begin
                    if (addr_counter_max == '0 || inter_counter_max == '0) begin
                        state_d = ST_ERR;
                    end else begin
                        addr_d  = '0;
                        pass_d  = '0;
                        abort_d = 1'b0;
                        state_d = ST_ACC;
                    end
                end
            end
            ST_ACC: begin
                if (glo_err) begin
                    state_d = ST_ERR;
                end else if (s_axis_tvalid) begin
                    if (s_axis_tlast != is_last) begin
                        state_d = ST_ERR;
                    end else begin
                        wdata_d   = s_axis_tdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_ISS;
                    end
                end
            end
            ST_ISS: begin
                if (glo_err) abort_d = 1'b1;
                if (m_axil_awready) awvalid_d = 1'b0;
                if (m_axil_wready)  wvalid_d  = 1'b0;
                if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                    bready_d = 1'b1;
                    state_d  = ST_RSP;
                end
            end
            ST_RSP: begin
                if (glo_err) abort_d = 1'b1;
                if (m_axil_bvalid) begin
                    bready_d = 1'b0;
                    if (m_axil_bresp != 2'b00) begin
                        state_d = ST_ERR;
                    end else begin
                        if (addr_wrap) begin
                            addr_d = '0;
                            pass_d = pass_sum[INTER_ITER_WIDTH-1:0];
                        end else begin
                            addr_d = addr_sum[ADDR_WIDTH-1:0];
                        end
                        if (is_last)                  state_d = ST_END;
                        else if (abort_q || glo_err)  state_d = ST_ERR;
                        else                          state_d = ST_ACC;
                    end
                end
            end
            ST_ERR: if (glo_err) state_d = ST_STR;
            ST_END: if (glo_fsm_state == GLO_FSM_END) state_d = ST_STR;
            default: state_d = ST_STR;
        endcase
        done_d  = (state_d == ST_END);
        error_d = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_STR;
            addr_q    <= '0;
            pass_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pass_q    <= pass_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            abort_q   <= abort_d;
        end
    end

endmodule

// File: tb/tb_mcu_local_axil_write_fsm.sv
// Bench for mcu_local_axil_write_fsm: stream source and AXI-Lite slave models plus a
// job-level reference (word k goes to address k mod words-per-pass).
module tb_mcu_local_axil_write_fsm;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam logic [1:0] G_IDLE = 2'd0, G_STR = 2'd1, G_END = 2'd2, G_ERR = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_awvalid, m_axil_awready = 1'b0;
    logic [DW-1:0] m_axil_wdata;
    logic [DW/8-1:0] m_axil_wstrb;
    logic          m_axil_wvalid, m_axil_wready = 1'b0;
    logic [1:0]    m_axil_bresp = 2'b00;
    logic          m_axil_bvalid = 1'b0, m_axil_bready;
    logic [1:0]    glo_fsm_state = G_IDLE;
    logic [AW:0]   addr_counter_max = '0;
    logic [IW-1:0] inter_counter_max = '0;
    logic          write_done, error;

    mcu_local_axil_write_fsm #(
        .GLO_FSM_WIDTH(2), .GLO_FSM_STR(G_STR), .GLO_FSM_END(G_END), .GLO_FSM_ERR(G_ERR),
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(DW/8), .INTER_ITER_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .glo_fsm_state(glo_fsm_state), .addr_counter_max(addr_counter_max),
        .inter_counter_max(inter_counter_max), .write_done(write_done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // slave / stream model state
    int aw_dly, w_dly, b_dly, aw_cnt, w_cnt, b_cnt, wr_cnt, err_wr;
    bit aw_got, w_got, rnd_dly, s_gap, s_en;
    bit s_hs_f, aw_hs_f, w_hs_f, b_hs_f;
    logic [DW-1:0] words[$];
    bit            tl[$];
    int            s_idx;
    // monitor records
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] wd_q[$];
    int            hs_cyc[$];
    int            cyc = 0, viol = 0;
    bit            pend_aw, pend_w;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    // expected job outcome
    int  exp_nw, exp_hs, job_acm;
    bit  exp_done;

    // Samples 1 time unit before each rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (rst) begin
                s_hs_f = 0; aw_hs_f = 0; w_hs_f = 0; b_hs_f = 0;
                pend_aw = 0; pend_w = 0;
            end else begin
                if (pend_aw && (!m_axil_awvalid || m_axil_awaddr != pend_addr)) viol++;
                if (pend_w && (!m_axil_wvalid || m_axil_wdata != pend_data)) viol++;
                if (m_axil_wstrb != '1 || m_axil_awprot != 3'b000) viol++;
                s_hs_f  = s_axis_tvalid && s_axis_tready;
                aw_hs_f = m_axil_awvalid && m_axil_awready;
                w_hs_f  = m_axil_wvalid && m_axil_wready;
                b_hs_f  = m_axil_bvalid && m_axil_bready;
                pend_aw = m_axil_awvalid && !m_axil_awready;
                pend_w  = m_axil_wvalid && !m_axil_wready;
                pend_addr = m_axil_awaddr;
                pend_data = m_axil_wdata;
                if (s_hs_f) hs_cyc.push_back(cyc);
                if (aw_hs_f) aw_q.push_back(m_axil_awaddr);
                if (w_hs_f) wd_q.push_back(m_axil_wdata);
            end
        end
    end

    task automatic pick_dly();
        if (rnd_dly) begin
            aw_dly = $urandom_range(0, 3);
            w_dly  = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3);
        end
    endtask

    // One cycle: drive stream source and slave at the falling edge
    task automatic tick();
        @(negedge clk);
        if (s_hs_f) begin s_idx++; s_axis_tvalid = 1'b0; end
        if (!s_axis_tvalid && s_en && s_idx < words.size() && (!s_gap || $urandom_range(0, 3) != 0)) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = words[s_idx];
            s_axis_tlast  = tl[s_idx];
        end
        if (aw_hs_f) begin m_axil_awready = 1'b0; aw_got = 1; aw_cnt = 0; end
        else if (m_axil_awvalid) begin
            if (aw_cnt >= aw_dly) m_axil_awready = 1'b1; else aw_cnt++;
        end
        if (w_hs_f) begin m_axil_wready = 1'b0; w_got = 1; w_cnt = 0; end
        else if (m_axil_wvalid) begin
            if (w_cnt >= w_dly) m_axil_wready = 1'b1; else w_cnt++;
        end
        if (b_hs_f) begin
            m_axil_bvalid = 1'b0; aw_got = 0; w_got = 0; b_cnt = 0; wr_cnt++;
            pick_dly();
        end else if (aw_got && w_got && !m_axil_bvalid) begin
            if (b_cnt >= b_dly) begin
                m_axil_bvalid = 1'b1;
                m_axil_bresp  = (wr_cnt == err_wr) ? 2'b10 : 2'b00;
            end else b_cnt++;
        end
    endtask

    task automatic clear_models();
        s_axis_tvalid = 0; m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
        m_axil_bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; wr_cnt = 0; aw_got = 0; w_got = 0;
        s_hs_f = 0; aw_hs_f = 0; w_hs_f = 0; b_hs_f = 0; s_idx = 0; s_en = 0;
        words.delete(); tl.delete(); aw_q.delete(); wd_q.delete(); hs_cyc.delete();
        viol = 0;
        pick_dly();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_tready"}, s_axis_tready, 0);
        chk({tag, "_awvalid"}, m_axil_awvalid, 0);
        chk({tag, "_wvalid"}, m_axil_wvalid, 0);
        chk({tag, "_bready"}, m_axil_bready, 0);
        chk({tag, "_done"}, write_done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_awaddr"}, m_axil_awaddr, 0);
        chk({tag, "_wdata"}, m_axil_wdata, 0);
    endtask

    // mode: 0 clean, 1 early tlast at bidx, 2 missing tlast, 3 bresp error on write bidx
    task automatic start_job(input int acm, input int icm, input int mode, input int bidx);
        int n;
        clear_models();
        n = acm * icm;
        job_acm = acm;
        addr_counter_max  = (AW+1)'(acm);
        inter_counter_max = IW'(icm);
        for (int k = 0; k < n; k++) begin
            words.push_back(DW'($urandom));
            tl.push_back(k == n - 1);
        end
        err_wr = (mode == 3) ? bidx : -1;
        case (mode)
            1: begin tl[bidx] = 1; exp_nw = bidx; exp_hs = bidx + 1; exp_done = 0; end
            2: begin tl[n-1] = 0; exp_nw = n - 1; exp_hs = n; exp_done = 0; end
            3: begin exp_nw = bidx + 1; exp_hs = bidx + 1; exp_done = 0; end
            default: begin exp_nw = n; exp_hs = n; exp_done = 1; end
        endcase
        s_en = 1;
        tick();
        glo_fsm_state = G_STR;
        tick();
        chk("ope_tready", s_axis_tready, 1);
        glo_fsm_state = G_IDLE;
    endtask

    task automatic finish_job(input bit thru);
        for (int c = 0; c < 3000 && !(write_done || error); c++) tick();
        chk("job_finished", write_done || error, 1);
        tick();
        tick();
        chk("write_done", write_done, exp_done);
        chk("error", error, !exp_done);
        chk("tready_after", s_axis_tready, 0);
        chk("n_aw", aw_q.size(), exp_nw);
        chk("n_w", wd_q.size(), exp_nw);
        chk("n_stream", hs_cyc.size(), exp_hs);
        for (int k = 0; k < exp_nw && k < aw_q.size() && k < wd_q.size(); k++) begin
            chk("awaddr", aw_q[k], k % job_acm);
            chk("wdata", wd_q[k], words[k]);
        end
        chk("protocol", viol, 0);
        if (thru)
            for (int k = 1; k < hs_cyc.size(); k++) chk("interval", hs_cyc[k] - hs_cyc[k-1], 3);
        glo_fsm_state = exp_done ? G_END : G_ERR;
        tick();
        chk("back_done", write_done, 0);
        chk("back_error", error, 0);
        glo_fsm_state = G_IDLE;
    endtask

    task automatic wait_bready(input int nth);
        int c = 0;
        while (!(m_axil_bready && hs_cyc.size() == nth) && c < 500) begin tick(); c++; end
        chk("reach_resp", m_axil_bready, 1);
    endtask

    initial begin
        rnd_dly = 0; s_gap = 0; aw_dly = 0; w_dly = 0; b_dly = 0; err_wr = -1;
        clear_models();
        rst = 1; tick(); tick();
        chk_idle_outputs("reset");
        rst = 0; tick();
        chk_idle_outputs("post_reset");

        // clean job against zero-wait slave
        start_job(4, 2, 0, 0);
        finish_job(1);

        // awready 3 cycles late, wready 2 cycles before it
        aw_dly = 3; w_dly = 1; b_dly = 0;
        start_job(4, 2, 0, 0);
        finish_job(0);
        aw_dly = 0; w_dly = 0;

        // zero-size jobs fail straight from STR
        for (int z = 0; z < 2; z++) begin
            clear_models();
            addr_counter_max  = (z == 0) ? '0 : (AW+1)'(4);
            inter_counter_max = (z == 0) ? IW'(2) : '0;
            tick();
            glo_fsm_state = G_STR;
            tick();
            chk("zero_error", error, 1);
            chk("zero_tready", s_axis_tready, 0);
            glo_fsm_state = G_IDLE;
            tick(); tick();
            chk("zero_no_aw", aw_q.size(), 0);
            glo_fsm_state = G_ERR;
            tick();
            chk("zero_back", error, 0);
            glo_fsm_state = G_IDLE;
        end

        // tlast on word 3 of 8, then bresp error on word 5
        start_job(4, 2, 1, 2);
        finish_job(0);
        start_job(4, 2, 3, 4);
        finish_job(0);

        // global ERR while the first write waits for its response
        b_dly = 4;
        start_job(4, 2, 0, 0);
        wait_bready(1);
        glo_fsm_state = G_ERR;
        tick();
        glo_fsm_state = G_IDLE;
        exp_nw = 1; exp_hs = 1; exp_done = 0;
        finish_job(0);

        // reset in RESP of the third word, then a fresh job
        b_dly = 10;
        start_job(4, 2, 0, 0);
        wait_bready(3);
        rst = 1;
        tick();
        chk_idle_outputs("mid_reset");
        tick();
        rst = 0;
        b_dly = 0;
        start_job(3, 2, 0, 0);
        finish_job(1);

        // randomized jobs, delays and stream gaps
        rnd_dly = 1; s_gap = 1;
        for (int j = 0; j < 12; j++) begin
            int acm, icm, mode, n, bidx;
            acm  = $urandom_range(1, 5);
            icm  = $urandom_range(1, 3);
            mode = $urandom_range(0, 3);
            n    = acm * icm;
            if (mode == 1 && n < 2) mode = 0;
            bidx = (mode == 1) ? $urandom_range(0, n - 2) : $urandom_range(0, n - 1);
            start_job(acm, icm, mode, bidx);
            finish_job(0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mcu_local_axil_write_fsm.md
# mcu_local_axil_write_fsm

Local write-side FSM for the MCU datapath: consumes an AXI-Stream of result words and writes them sequentially into an AXI-Lite slave memory. The address counter wraps at `addr_counter_max`, and the pass count is bounded by `inter_counter_max`. It sits beside the local read FSMs under the same global FSM, and reports completion and error back to that global FSM.

## Interface
- `GLO_FSM_WIDTH`, `GLO_FSM_STR`, `GLO_FSM_END`, `GLO_FSM_ERR`: global FSM encoding, from the shared global-FSM parameter header.
- `DATA_WIDTH`, default 16: AXI-Lite data width and AXI-Stream data width.
- `ADDR_WIDTH`, default 32: AXI-Lite address width.
- `STRB_WIDTH`, default `DATA_WIDTH/8`: write strobe width.
- `INTER_ITER_WIDTH`, default 32: width of the pass counter.
- `clk`  in  1  clock; everything is synchronous to it.
- `rst`  in  1  reset; synchronous, active-high.
- `s_axis_tdata`  in  `DATA_WIDTH`  stream word.
- `s_axis_tvalid` / `s_axis_tready`  in / out  1  stream handshake.
- `s_axis_tlast`  in  1  marks the final word of the whole job.
- `m_axil_awaddr`  out  `ADDR_WIDTH`  word index (address counter value).
- `m_axil_awprot`  out  3  constant `3'b000`.
- `m_axil_awvalid` / `m_axil_awready`  out / in  1  write-address handshake.
- `m_axil_wdata`  out  `DATA_WIDTH`  registered stream word.
- `m_axil_wstrb`  out  `STRB_WIDTH`  all ones.
- `m_axil_wvalid` / `m_axil_wready`  out / in  1  write-data handshake.
- `m_axil_bresp`  in  2  write response.
- `m_axil_bvalid` / `m_axil_bready`  in / out  1  write-response handshake.
- `glo_fsm_state`  in  `GLO_FSM_WIDTH`  global FSM state.
- `addr_counter_max`  in  `ADDR_WIDTH+1`  number of words per pass.
- `inter_counter_max`  in  `INTER_ITER_WIDTH`  number of passes.
- `write_done`  out  1  high while in END.
- `error`  out  1  high while in ERR.

## Operation
- Local states: STR, OPE, ERR, END. Reset state is STR.
- STR:
  - Stays in STR until `glo_fsm_state == GLO_FSM_STR`.
  - Then, if `addr_counter_max == 0` or `inter_counter_max == 0`, goes to ERR.
  - Otherwise clears both counters and goes to OPE.
- OPE has three sub-phases:
  - ACCEPT: `s_axis_tready = 1`. On a handshake, the word is latched into `wdata`, and `awvalid` and `wvalid` are set.
  - ISSUE: `awvalid` and `wvalid` are held independently. Each drops in the cycle after its own ready handshake. Neither valid is ever withdrawn before its handshake.
  - RESP: entered once both handshakes are done. `bready = 1` until `bvalid`.
- Counters advance on every successful `bvalid` handshake (`bresp == 2'b00`):
  - `addr` increments by 1.
  - When `addr + 1 == addr_counter_max`, `addr` wraps to 0 and `pass` increments.
  - Counter arithmetic uses `ADDR_WIDTH+1` / `INTER_ITER_WIDTH+1` bit sums, so compares never overflow.
- The last word is the one at `addr == addr_counter_max-1` in pass `inter_counter_max-1`.
- tlast check is done at ACCEPT:
  - `tlast = 1` on a non-last word is an error.
  - `tlast = 0` on the last word is an error.
  - On a mismatch the word is discarded, no write is issued, and the FSM goes to ERR.
- A successful response for the last word moves the FSM to END.
- Any `bresp != 2'b00` moves the FSM to ERR after the B handshake.
- If `glo_fsm_state == GLO_FSM_ERR` while in OPE:
  - A write already in ISSUE or RESP is completed first.
  - The FSM then goes to ERR. No further words are accepted.
- END: held until `glo_fsm_state == GLO_FSM_END`, then goes to STR.
- ERR: held until `glo_fsm_state == GLO_FSM_ERR`, then goes to STR.
- Reset values:
  - All valids, `s_axis_tready`, `m_axil_bready`, `write_done` and `error` are 0.
  - `awaddr` and `wdata` are 0.
  - Counters are 0.
- Reset mid-operation: everything returns to STR on the next edge, and in-flight AXI-Lite transactions are abandoned.

## Timing
- All outputs are registered except `s_axis_tready`, which is decoded from state.
- There is at most one outstanding write.
- Stream handshake in cycle N:
  - `awvalid`, `wvalid`, `awaddr` and `wdata` are valid from N+1.
  - With `awready = wready = 1` at N+1, `bready` is high from N+2.
  - `bvalid` at N+2 makes `s_axis_tready` high again at N+3.
- Sustained throughput is 1 word per 3 cycles against a zero-wait slave.
- `awready` and `wready` may arrive in either order or in the same cycle; RESP is entered the cycle after the later one.
- STR to OPE takes 1 cycle after `GLO_FSM_STR` is seen. `s_axis_tready` rises in the first OPE cycle.
- `write_done` and `error` rise in the cycle the state register enters END or ERR.
- A `bresp` error and a global ERR in the same cycle both lead to ERR; that is a single transition.

## Test plan
- `addr_counter_max=4`, `inter_counter_max=2`, 8 words with tlast on the 8th, zero-wait slave -> writes to 0,1,2,3,0,1,2,3 with matching data, END with `write_done=1`, `error=0`; `GLO_FSM_END` returns the FSM to STR.
- Same job, with `awready` delayed 3 cycles and `wready` arriving 2 cycles before it -> valids are held until their handshakes, one write per word, same address sequence.
- `addr_counter_max=0` with `GLO_FSM_STR` -> ERR the next cycle, `error=1`, no AXI traffic; `GLO_FSM_ERR` returns the FSM to STR.
- tlast on word 3 of 8 -> word 3 is never written, `error=1`, `s_axis_tready=0`.
- `bresp=2'b10` on word 5 -> ERR after the B handshake, no word 6 is accepted.
- Reset asserted during RESP -> next cycle all outputs are 0, state is STR, and a fresh job completes normally.
